// File: rtl/ppm_pkg.sv
// Shared constants for pulse_period_meter: FSM encodings, lock-run width and run update helper.
package ppm_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_OVF     = 2'd2;

  localparam int unsigned RUN_W = 4;

  // Next lock-run value: restart at 1 on a first or differing period, else count up to lim.
  function automatic logic [RUN_W-1:0] run_next(input logic [RUN_W-1:0] run,
                                                 input logic             same,
                                                 input logic [RUN_W-1:0] lim);
    logic [RUN_W-1:0] v;
    if (run == '0 || !same) begin
      v = RUN_W'(1);
    end else if (run >= lim) begin
      v = lim;
    end else begin
      v = run + RUN_W'(1);
    end
    return v;
  endfunction

endpackage

// File: rtl/pulse_period_meter_rise_detect.sv
// Rising-edge detector for a clock-synchronous pulse stream; rise_c is combinational.
module rise_detect (
  input  logic clock,
  input  logic resetn,
  input  logic pulse_in,
  output logic rise_c
);

  logic r_prev;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= pulse_in;
    end
  end

  assign rise_c = pulse_in & ~r_prev;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures edge-to-edge period of a tick stream, with lock and sticky overflow flags.
// Optional min/max period tracking is enabled by defining PERIOD_MINMAX_EN.
module pulse_period_meter
  import ppm_pkg::*;
#(
  parameter int unsigned CNT_W  = 28,
  parameter int unsigned LOCK_N = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             pulse_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             overflow
`ifdef PERIOD_MINMAX_EN
  ,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(LOCK_N);

  logic             w_rise;
  logic [1:0]       r_state,  w_state_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic             r_valid,  w_valid_nxt;
  logic [RUN_W-1:0] r_run,    w_run_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_ovf,    w_ovf_nxt;
  logic [RUN_W-1:0] w_run_upd;

  rise_detect u_rise (
    .clock    (clock),
    .resetn   (resetn),
    .pulse_in (pulse_in),
    .rise_c   (w_rise)
  );

  assign w_run_upd = run_next(r_run, (r_cnt == r_period), RUN_LIM);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_run    <= '0;
      r_locked <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_period <= w_period_nxt;
      r_valid  <= w_valid_nxt;
      r_run    <= w_run_nxt;
      r_locked <= w_locked_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  // Clear beats any edge; an edge beats saturation so the all-ones period is still reported.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period;
    w_valid_nxt  = 1'b0;
    w_run_nxt    = r_run;
    w_locked_nxt = r_locked;
    w_ovf_nxt    = r_ovf;
    if (clear) begin
      w_state_nxt  = ST_IDLE;
      w_cnt_nxt    = '0;
      w_run_nxt    = '0;
      w_locked_nxt = 1'b0;
      w_ovf_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            w_period_nxt = r_cnt;
            w_valid_nxt  = 1'b1;
            w_cnt_nxt    = CNT_W'(1);
            w_run_nxt    = w_run_upd;
            w_locked_nxt = (w_run_upd == RUN_LIM);
          end else if (r_cnt == CNT_MAX) begin
            w_state_nxt  = ST_OVF;
            w_ovf_nxt    = 1'b1;
            w_locked_nxt = 1'b0;
            w_run_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_OVF: begin
          if (w_rise) begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = ST_MEASURE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign period       = r_period;
  assign period_valid = r_valid;
  assign locked       = r_locked;
  assign overflow     = r_ovf;

`ifdef PERIOD_MINMAX_EN
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_min <= '1;
      r_max <= '0;
    end else if (clear) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_valid_nxt) begin
      if (w_period_nxt < r_min) r_min <= w_period_nxt;
      if (w_period_nxt > r_max) r_max <= w_period_nxt;
    end
  end

  assign min_period = r_min;
  assign max_period = r_max;
`endif

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: table of edge spacings plus hand-written corner sequences.
module tb_pulse_period_meter;
  import ppm_pkg::*;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        pulse  = 1'b0;
  logic        clr    = 1'b0;
  logic        pulse4 = 1'b0;
  logic        clr4   = 1'b0;
  logic [27:0] period;
  logic        valid, locked, ovf;
  logic [3:0]  period4;
  logic        valid4, locked4, ovf4;
`ifdef PERIOD_MINMAX_EN
  logic [27:0] min_p, max_p;
  logic [3:0]  min_p4, max_p4;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          gap;
    logic        exp_valid;
    logic [27:0] exp_period;
    logic        exp_locked;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  pulse_period_meter #(.CNT_W(28), .LOCK_N(3)) u_dut (
    .clock        (clk),
    .resetn       (rst_n),
    .pulse_in     (pulse),
    .clear        (clr),
    .period       (period),
    .period_valid (valid),
    .locked       (locked),
    .overflow     (ovf)
`ifdef PERIOD_MINMAX_EN
    ,
    .min_period   (min_p),
    .max_period   (max_p)
`endif
  );

  pulse_period_meter #(.CNT_W(4), .LOCK_N(3)) u_dut4 (
    .clock        (clk),
    .resetn       (rst_n),
    .pulse_in     (pulse4),
    .clear        (clr4),
    .period       (period4),
    .period_valid (valid4),
    .locked       (locked4),
    .overflow     (ovf4)
`ifdef PERIOD_MINMAX_EN
    ,
    .min_period   (min_p4),
    .max_period   (max_p4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Low for gap-1 cycles, then a one-cycle pulse; returns just after the rise edge.
  task automatic send_edge(input int gap, input bit sel4);
    if (sel4) pulse4 = 1'b0; else pulse = 1'b0;
    repeat (gap - 1) tick();
    if (sel4) pulse4 = 1'b1; else pulse = 1'b1;
    tick();
    if (sel4) pulse4 = 1'b0; else pulse = 1'b0;
  endtask

  initial begin
    int nv;
    vecs[0] = '{5,  1'b0, 28'd0,  1'b0};
    vecs[1] = '{30, 1'b1, 28'd30, 1'b0};
    vecs[2] = '{30, 1'b1, 28'd30, 1'b0};
    vecs[3] = '{30, 1'b1, 28'd30, 1'b1};
    vecs[4] = '{30, 1'b1, 28'd30, 1'b1};
    vecs[5] = '{31, 1'b1, 28'd31, 1'b0};
    vecs[6] = '{31, 1'b1, 28'd31, 1'b0};
    vecs[7] = '{31, 1'b1, 28'd31, 1'b1};

    repeat (2) tick();
    check("rst_period", 32'(period), 32'd0);
    check("rst_valid",  32'(valid),  32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_ovf",    32'(ovf),    32'd0);
    #3 rst_n = 1'b1;
    tick();
    check("rst_state", 32'(u_dut.r_state), 32'(ST_IDLE));

    for (int i = 0; i < 8; i++) begin
      send_edge(vecs[i].gap, 1'b0);
      check($sformatf("vec%0d_valid", i),  32'(valid),  32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_period", i), 32'(period), 32'(vecs[i].exp_period));
      check($sformatf("vec%0d_locked", i), 32'(locked), 32'(vecs[i].exp_locked));
      check($sformatf("vec%0d_ovf", i),    32'(ovf),    32'd0);
    end

    // clear coincident with a rise while locked
    pulse = 1'b0;
    repeat (9) tick();
    pulse = 1'b1;
    clr   = 1'b1;
    tick();
    pulse = 1'b0;
    clr   = 1'b0;
    check("clr_valid",  32'(valid),  32'd0);
    check("clr_locked", 32'(locked), 32'd0);
    check("clr_state",  32'(u_dut.r_state), 32'(ST_IDLE));
    check("clr_period", 32'(period), 32'd31);
    send_edge(3, 1'b0);
    check("clr_first_valid", 32'(valid), 32'd0);
    send_edge(10, 1'b0);
    check("clr_next_valid",  32'(valid),  32'd1);
    check("clr_next_period", 32'(period), 32'd10);
    check("clr_next_locked", 32'(locked), 32'd0);

    // level held high for 5 cycles counts as one edge
    clr = 1'b1;
    tick();
    clr = 1'b0;
    pulse = 1'b1;
    tick();
    check("held_first_valid", 32'(valid), 32'd0);
    nv = 0;
    for (int k = 1; k < 20; k++) begin
      pulse = (k < 5);
      tick();
      nv += int'(valid);
    end
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
    check("held_extra_valids", 32'(nv),     32'd0);
    check("held_valid",        32'(valid),  32'd1);
    check("held_period",       32'(period), 32'd20);

    // 4-bit counter saturation, recovery and edge/saturation collision
    send_edge(3, 1'b1);
    check("ovf_first_valid", 32'(valid4), 32'd0);
    repeat (14) tick();
    check("ovf_before", 32'(ovf4), 32'd0);
    tick();
    check("ovf_set",    32'(ovf4),    32'd1);
    check("ovf_state",  32'(u_dut4.r_state), 32'(ST_OVF));
    check("ovf_locked", 32'(locked4), 32'd0);
    send_edge(4, 1'b1);
    check("ovf_edge_valid", 32'(valid4), 32'd0);
    check("ovf_edge_state", 32'(u_dut4.r_state), 32'(ST_MEASURE));
    check("ovf_edge_ovf",   32'(ovf4),   32'd1);
    send_edge(7, 1'b1);
    check("ovf_p7_valid",  32'(valid4),  32'd1);
    check("ovf_p7_period", 32'(period4), 32'd7);
    check("ovf_p7_ovf",    32'(ovf4),    32'd1);
    send_edge(15, 1'b1);
    check("sat_valid",  32'(valid4),  32'd1);
    check("sat_period", 32'(period4), 32'd15);
    check("sat_state",  32'(u_dut4.r_state), 32'(ST_MEASURE));

    // asynchronous reset in the middle of a count
    pulse = 1'b0;
    repeat (5) tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_period",  32'(period),  32'd0);
    check("arst_valid",   32'(valid),   32'd0);
    check("arst_locked",  32'(locked),  32'd0);
    check("arst_ovf4",    32'(ovf4),    32'd0);
    check("arst_period4", 32'(period4), 32'd0);
    check("arst_state",   32'(u_dut.r_state), 32'(ST_IDLE));
    #2 rst_n = 1'b1;
    send_edge(3, 1'b0);
    check("arst_first_valid", 32'(valid), 32'd0);
    send_edge(12, 1'b0);
    check("arst_next_valid",  32'(valid),  32'd1);
    check("arst_next_period", 32'(period), 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
Receive-side companion to the tick generators. Takes a tick or strobe stream, such as the output of a rate divider, and recovers its period in clock cycles. Reports each measured period with a one-cycle valid strobe. Flags lock once the period has been stable for several measurements, and flags overflow when the tick stream stops. Used to check and calibrate the game-timing ticks on the DE2 board.

Parameters:
CNT_W, 28, width of the cycle counter and of period; 28 matches the widest divider counter.
LOCK_N, 3, number of consecutive identical periods required before locked asserts; legal range 2..15.

Ports:
clock  input  1  system clock; all state updates on its rising edge.
resetn  input  1  asynchronous, active-low reset.
pulse_in  input  1  tick under measurement; only rising edges are counted, so a level held high counts once.
clear  input  1  synchronous restart: return to IDLE and clear lock and overflow; the period register is kept.
period  output  CNT_W  last measured edge-to-edge distance in cycles; reset 0.
period_valid  output  1  one-cycle strobe when period updates; reset 0.
locked  output  1  high while the last LOCK_N periods were identical; reset 0.
overflow  output  1  sticky; set when the counter saturates without an edge; reset 0.

Behaviour:
- Edge detect:
  - prev register, reset 0; rise = pulse_in & ~prev.
  - pulse_in is synchronous to clock; no synchroniser.
- States (2-bit): IDLE, MEASURE, OVF. Reset state is IDLE.
- IDLE:
  - on rise: cnt <= 1, go to MEASURE.
  - no period_valid from the first edge.
- MEASURE, counting:
  - each cycle without rise: cnt <= cnt + 1.
  - cnt at cycle t0+k equals k, where t0 is the edge cycle.
- MEASURE, on rise:
  - period <= cnt; period_valid = 1 in the next cycle; cnt <= 1.
  - Result: a divider with reload R produces period = R+1. Reload 29 gives 30.
- Latency: period and period_valid are registered, visible 1 cycle after the rise cycle.
- Saturation:
  - in MEASURE, if cnt == all-ones and there is no rise: go to OVF, overflow <= 1, locked <= 0, lock run <= 0.
  - cnt holds at all-ones, with no wrap.
- Edge and saturation in the same cycle: the edge wins. Report period = all-ones and stay in MEASURE.
- OVF:
  - on rise: cnt <= 1, go to MEASURE; no period_valid.
  - overflow stays set until clear or reset.
- Lock tracking (run counter, 4 bits, saturating at LOCK_N):
  - first valid period after IDLE/OVF: run = 1.
  - period equal to the previous period: run + 1.
  - period differs: run = 1.
  - locked = (run == LOCK_N); it updates in the same cycle as period_valid.
- clear:
  - has priority over rise.
  - next state IDLE; run, locked, overflow and period_valid go to 0.
  - period keeps its value.
- Reset mid-measurement: all registers go to reset values immediately; the partial count is discarded.

Optional Feature:
PERIOD_MINMAX_EN:
- Defined:
  - adds outputs min_period and max_period (each CNT_W wide).
  - reset values: all-ones and 0 respectively.
  - updated on every period_valid; re-initialised by clear.
  - saturated periods from the edge/saturation collision are included.
- Not defined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ppm_pkg holds:
  - the state encodings ST_IDLE = 2'd0, ST_MEASURE = 2'd1, ST_OVF = 2'd2;
  - the run counter width constant RUN_W = 4.
- One natural sub-module, rise_detect: the prev register plus the rise output, with clock/resetn.
- Counter, FSM and lock logic stay in the top level.

Test Plan:
- 1-cycle pulses every 30 cycles (rate_divider30 pattern): first edge gives no valid; then valid with period = 30 each time. locked = 1 on the 3rd valid.
- Periods 30, 30, 31, 31, 31: locked drops at 31, re-asserts on the third 31.
- pulse_in held high for 5 cycles, then low, with the next rise 20 cycles after the first: period = 20 and one valid only.
- CNT_W = 4, no second edge: after 15 counts overflow = 1, state OVF, locked = 0. The next edge gives no valid; the following edge 7 cycles later gives period = 7, and overflow stays 1.
- clear asserted the same cycle as a rise while locked: no valid, locked = 0, state IDLE, period unchanged. The next two edges spaced 10 give period = 10.
- resetn pulsed low mid-count (asynchronous, between clock edges): all outputs go to 0 immediately. After release, the first edge produces no valid.
